// File: rtl/des_pkg.sv
// Shared DES definitions: FSM states, round shift schedule, permutation/S-box tables
// and the bit-level helper functions used by the round datapath and the controller.
package des_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam int SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Tables use DES numbering: entry value n selects bit n counted from the MSB (1-based).
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    // Each box is stored row-major: index = row*16 + column.
    localparam logic [3:0] SBOX [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

    function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
        return (x << n) | (x >> (28 - n));
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
        return (x >> n) | (x << (28 - n));
    endfunction

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    function automatic logic [55:0] pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] feistel_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [5:0]  b;
        logic [31:0] s;
        logic [31:0] y;
        for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
        x = x ^ k;
        for (int j = 0; j < 8; j++) begin
            b = x[47-6*j -: 6];
            s[31-4*j -: 4] = SBOX[j][{b[5], b[0], b[4:1]}];
        end
        for (int i = 0; i < 32; i++) y[31-i] = s[32-P_T[i]];
        return y;
    endfunction

endpackage

// File: rtl/des_fp.sv
// DES final (inverse initial) permutation, purely combinational.
module des_fp
    import des_pkg::*;
(
    input  logic [63:0] data,
    output logic [63:0] perm
);
    assign perm = fp_perm(data);
endmodule

// File: rtl/des_ip.sv
// DES initial permutation, purely combinational.
module des_ip
    import des_pkg::*;
(
    input  logic [63:0] data,
    output logic [63:0] perm
);
    assign perm = ip_perm(data);
endmodule

// File: rtl/des_round.sv
// One combinational Feistel round plus the matching key-schedule step.
// Encrypt rotates C/D before deriving the subkey; decrypt derives it first, then rotates back.
module des_round
    import des_pkg::*;
(
    input  logic [31:0] l,
    input  logic [31:0] r,
    input  logic [27:0] c,
    input  logic [27:0] d,
    input  logic        mode,
    input  logic [3:0]  rnd,
    output logic [31:0] l_next,
    output logic [31:0] r_next,
    output logic [27:0] c_next,
    output logic [27:0] d_next
);
    logic [27:0] c_enc;
    logic [27:0] d_enc;
    logic [47:0] subkey;

    always_comb begin
        c_enc  = rotl28(c, SHIFT[rnd]);
        d_enc  = rotl28(d, SHIFT[rnd]);
        subkey = mode ? pc2({c, d}) : pc2({c_enc, d_enc});
        l_next = r;
        r_next = l ^ feistel_f(r, subkey);
        c_next = mode ? rotr28(c, SHIFT[4'd15 - rnd]) : c_enc;
        d_next = mode ? rotr28(d, SHIFT[4'd15 - rnd]) : d_enc;
    end
endmodule

// File: rtl/des_iter_controller.sv
// Iterative DES sequencer: accepts a block/key, runs 16 rounds UNROLL per clock,
// and holds the final-permuted result until the consumer takes it.
module des_iter_controller
    import des_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [63:0] in_key,
    input  logic        in_decrypt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy
);
    generate
        if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : g_bad_unroll
            $error("des_iter_controller: UNROLL must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] l_reg;
    logic [31:0] r_reg;
    logic [27:0] c_reg;
    logic [27:0] d_reg;
    logic        mode_reg;
    logic [4:0]  rnd_reg;
    logic [63:0] out_data_reg;

    logic [63:0] ip_data;
    logic [63:0] fp_data;
    logic [55:0] key_pc1;
    logic        last_step;

    logic [31:0] l_chain [UNROLL+1];
    logic [31:0] r_chain [UNROLL+1];
    logic [27:0] c_chain [UNROLL+1];
    logic [27:0] d_chain [UNROLL+1];

    des_ip u_ip (
        .data (in_data),
        .perm (ip_data)
    );

    assign key_pc1 = pc1(in_key);

    assign l_chain[0] = l_reg;
    assign r_chain[0] = r_reg;
    assign c_chain[0] = c_reg;
    assign d_chain[0] = d_reg;

    generate
        for (genvar gi = 0; gi < UNROLL; gi++) begin : g_round
            des_round u_round (
                .l      (l_chain[gi]),
                .r      (r_chain[gi]),
                .c      (c_chain[gi]),
                .d      (d_chain[gi]),
                .mode   (mode_reg),
                .rnd    (rnd_reg[3:0] + 4'(gi)),
                .l_next (l_chain[gi+1]),
                .r_next (r_chain[gi+1]),
                .c_next (c_chain[gi+1]),
                .d_next (d_chain[gi+1])
            );
        end
    endgenerate

    // The halves are swapped (R16 first) before the final permutation.
    des_fp u_fp (
        .data ({r_chain[UNROLL], l_chain[UNROLL]}),
        .perm (fp_data)
    );

    assign last_step = (rnd_reg + 5'(UNROLL)) == 5'd16;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)  state_next = ROUND;
            ROUND:   if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            l_reg        <= '0;
            r_reg        <= '0;
            c_reg        <= '0;
            d_reg        <= '0;
            mode_reg     <= 1'b0;
            rnd_reg      <= '0;
            out_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        {l_reg, r_reg} <= ip_data;
                        {c_reg, d_reg} <= key_pc1;
                        mode_reg       <= in_decrypt;
                        rnd_reg        <= '0;
                    end
                end
                ROUND: begin
                    l_reg   <= l_chain[UNROLL];
                    r_reg   <= r_chain[UNROLL];
                    c_reg   <= c_chain[UNROLL];
                    d_reg   <= d_chain[UNROLL];
                    rnd_reg <= rnd_reg + 5'(UNROLL);
                    if (last_step) out_data_reg <= fp_data;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign out_data  = out_data_reg;
endmodule

// File: tb/tb_des_iter_controller.sv
// Directed bench for des_iter_controller: four instances (UNROLL 1, 2, 4, 16) share
// data/key/out_ready; each has its own in_valid so only the addressed one runs.
module tb_des_iter_controller;

    localparam int UV [4] = '{1, 2, 4, 16};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid [4];
    logic [63:0] in_data;
    logic [63:0] in_key;
    logic        in_decrypt;
    logic        out_ready;
    logic        in_ready_u  [4];
    logic        out_valid_u [4];
    logic        busy_u      [4];
    logic [63:0] out_data_u  [4];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dut
            des_iter_controller #(.UNROLL(UV[gi])) u_dut (
                .clk        (clk),
                .rst        (rst),
                .in_valid   (in_valid[gi]),
                .in_ready   (in_ready_u[gi]),
                .in_data    (in_data),
                .in_key     (in_key),
                .in_decrypt (in_decrypt),
                .out_valid  (out_valid_u[gi]),
                .out_ready  (out_ready),
                .out_data   (out_data_u[gi]),
                .busy       (busy_u[gi])
            );
        end
    endgenerate

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one block on instance u, wait for out_valid, then complete the handshake.
    task automatic run_block(input int u, input logic [63:0] d, input logic [63:0] k,
                             input logic dec, output logic [63:0] res, output int lat);
        in_data     = d;
        in_key      = k;
        in_decrypt  = dec;
        in_valid[u] = 1'b1;
        step();
        in_valid[u] = 1'b0;
        in_data     = ~d;
        in_key      = ~k;
        in_decrypt  = ~dec;
        lat = 0;
        while (!out_valid_u[u] && lat < 40) begin
            step();
            lat++;
        end
        res = out_data_u[u];
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        $display("txn u=%0d dec=%0b in=%h key=%h -> out=%h latency=%0d", UV[u], dec, d, k, res, lat);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        for (int u = 0; u < 4; u++) begin
            n_cmp++; if (in_ready_u[u] !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready u%0d: got %b expected 1", UV[u], in_ready_u[u]); end
            n_cmp++; if (out_valid_u[u] !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid u%0d: got %b expected 0", UV[u], out_valid_u[u]); end
            n_cmp++; if (busy_u[u] !== 1'b0) begin n_bad++; $display("FAIL reset_busy u%0d: got %b expected 0", UV[u], busy_u[u]); end
            n_cmp++; if (out_data_u[u] !== 64'h0) begin n_bad++; $display("FAIL reset_out_data u%0d: got %h expected 0", UV[u], out_data_u[u]); end
        end
        rst = 1'b0;
        step();
        n_cmp++; if (in_ready_u[0] !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready_u[0]); end
        $display("txn reset done");
    endtask

    task automatic test_encrypt();
        logic [63:0] res;
        int lat;
        run_block(0, 64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0, res, lat);
        n_cmp++; if (res !== 64'h85E813540F0AB405) begin n_bad++; $display("FAIL encrypt_data: got %h expected 85e813540f0ab405", res); end
        n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL encrypt_latency: got %0d expected 16", lat); end
        n_cmp++; if (in_ready_u[0] !== 1'b1) begin n_bad++; $display("FAIL encrypt_in_ready_after: got %b expected 1", in_ready_u[0]); end
    endtask

    task automatic test_decrypt();
        logic [63:0] res;
        int lat;
        run_block(0, 64'h85E813540F0AB405, 64'h133457799BBCDFF1, 1'b1, res, lat);
        n_cmp++; if (res !== 64'h0123456789ABCDEF) begin n_bad++; $display("FAIL decrypt_data: got %h expected 0123456789abcdef", res); end
        n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL decrypt_latency: got %0d expected 16", lat); end
        run_block(0, 64'h8787878787878787, 64'h0E329232EA6D0D73, 1'b0, res, lat);
        n_cmp++; if (res !== 64'h0000000000000000) begin n_bad++; $display("FAIL encrypt2_data: got %h expected 0000000000000000", res); end
    endtask

    task automatic test_backpressure();
        int cnt;
        in_data = 64'h0123456789ABCDEF; in_key = 64'h133457799BBCDFF1; in_decrypt = 1'b0;
        in_valid[0] = 1'b1;
        step();
        in_valid[0] = 1'b0;
        cnt = 0;
        while (!out_valid_u[0] && cnt < 40) begin step(); cnt++; end
        n_cmp++; if (out_valid_u[0] !== 1'b1) begin n_bad++; $display("FAIL bp_wait_done: out_valid %b after %0d cycles", out_valid_u[0], cnt); end
        for (int i = 0; i < 5; i++) begin
            in_valid[0] = 1'b1;
            in_data     = 64'hFFFF0000FFFF0000 ^ 64'(i);
            in_decrypt  = 1'b1;
            step();
            n_cmp++; if (out_valid_u[0] !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid c%0d: got %b expected 1", i, out_valid_u[0]); end
            n_cmp++; if (out_data_u[0] !== 64'h85E813540F0AB405) begin n_bad++; $display("FAIL bp_out_data c%0d: got %h expected 85e813540f0ab405", i, out_data_u[0]); end
            n_cmp++; if (in_ready_u[0] !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready c%0d: got %b expected 0", i, in_ready_u[0]); end
        end
        in_valid[0] = 1'b0;
        out_ready   = 1'b1;
        step();
        out_ready   = 1'b0;
        n_cmp++; if (out_valid_u[0] !== 1'b0) begin n_bad++; $display("FAIL bp_release_out_valid: got %b expected 0", out_valid_u[0]); end
        n_cmp++; if (in_ready_u[0] !== 1'b1) begin n_bad++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready_u[0]); end
        n_cmp++; if (busy_u[0] !== 1'b0) begin n_bad++; $display("FAIL bp_no_capture_busy: got %b expected 0", busy_u[0]); end
        $display("txn backpressure held 5 cycles, out=%h", out_data_u[0]);
    endtask

    task automatic test_back_to_back();
        logic [63:0] vd [4] = '{64'h0123456789ABCDEF, 64'h85E813540F0AB405, 64'h8787878787878787, 64'h0000000000000000};
        logic [63:0] vk [4] = '{64'h133457799BBCDFF1, 64'h133457799BBCDFF1, 64'h0E329232EA6D0D73, 64'h0E329232EA6D0D73};
        logic        vm [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [63:0] ve [4] = '{64'h85E813540F0AB405, 64'h0123456789ABCDEF, 64'h0000000000000000, 64'h8787878787878787};
        int cyc = 0;
        int n_acc = 0;
        int n_out = 0;
        int last_acc = 0;
        logic acc;
        logic hs;
        out_ready = 1'b1;
        while (n_out < 4 && cyc < 200) begin
            if (n_acc < 4) begin
                in_valid[0] = 1'b1;
                in_data     = vd[n_acc];
                in_key      = vk[n_acc];
                in_decrypt  = vm[n_acc];
            end else begin
                in_valid[0] = 1'b0;
            end
            acc = in_valid[0] && in_ready_u[0];
            hs  = out_valid_u[0];
            if (hs) begin
                n_cmp++; if (out_data_u[0] !== ve[n_out]) begin n_bad++; $display("FAIL b2b_data blk%0d: got %h expected %h", n_out, out_data_u[0], ve[n_out]); end
                $display("txn b2b result blk%0d out=%h at cycle %0d", n_out, out_data_u[0], cyc);
                n_out++;
            end
            step();
            cyc++;
            if (acc) begin
                if (n_acc > 0) begin
                    n_cmp++; if (cyc - last_acc !== 18) begin n_bad++; $display("FAIL b2b_spacing blk%0d: got %0d expected 18", n_acc, cyc - last_acc); end
                end
                last_acc = cyc;
                n_acc++;
            end
        end
        in_valid[0] = 1'b0;
        out_ready   = 1'b0;
        n_cmp++; if (n_out !== 4) begin n_bad++; $display("FAIL b2b_timeout: got %0d results expected 4", n_out); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] res;
        int lat;
        logic seen = 1'b0;
        in_data = 64'h0123456789ABCDEF; in_key = 64'h133457799BBCDFF1; in_decrypt = 1'b0;
        in_valid[0] = 1'b1;
        step();
        in_valid[0] = 1'b0;
        repeat (8) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (in_ready_u[0] !== 1'b1) begin n_bad++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready_u[0]); end
        n_cmp++; if (busy_u[0] !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b expected 0", busy_u[0]); end
        repeat (20) begin
            if (out_valid_u[0]) seen = 1'b1;
            step();
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid: got %b expected 0", seen); end
        $display("txn mid-round reset, block discarded");
        run_block(0, 64'h8787878787878787, 64'h0E329232EA6D0D73, 1'b0, res, lat);
        n_cmp++; if (res !== 64'h0000000000000000) begin n_bad++; $display("FAIL midrst_next_data: got %h expected 0000000000000000", res); end
        n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL midrst_next_latency: got %0d expected 16", lat); end
    endtask

    task automatic test_unroll();
        int exp_lat [4] = '{16, 8, 4, 1};
        logic [63:0] res;
        int lat;
        for (int u = 1; u < 4; u++) begin
            run_block(u, 64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0, res, lat);
            n_cmp++; if (res !== 64'h85E813540F0AB405) begin n_bad++; $display("FAIL unroll%0d_enc_data: got %h expected 85e813540f0ab405", UV[u], res); end
            n_cmp++; if (lat !== exp_lat[u]) begin n_bad++; $display("FAIL unroll%0d_enc_latency: got %0d expected %0d", UV[u], lat, exp_lat[u]); end
            run_block(u, 64'h85E813540F0AB405, 64'h133457799BBCDFF1, 1'b1, res, lat);
            n_cmp++; if (res !== 64'h0123456789ABCDEF) begin n_bad++; $display("FAIL unroll%0d_dec_data: got %h expected 0123456789abcdef", UV[u], res); end
            n_cmp++; if (lat !== exp_lat[u]) begin n_bad++; $display("FAIL unroll%0d_dec_latency: got %0d expected %0d", UV[u], lat, exp_lat[u]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) in_valid[i] = 1'b0;
        in_data    = '0;
        in_key     = '0;
        in_decrypt = 1'b0;
        out_ready  = 1'b0;
        #1;
        test_reset();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_unroll();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
